pong_2p_ctrl: RTL and testbench
===============================

Name: pong_2p_ctrl

Overview:
- Game-control FSM for the two-player pong screen. It is the consumer side of the graph block's miss/serve interface.
- Takes left_miss and right_miss from the graph animator. Keeps both players' BCD scores, times the pause between balls, and decides the winner.
- Drives gra_still and next_toss back to the animator. Exports state, scores and winner to the text/overlay logic.

Parameters:
- WIN_BCD, 8'h11, winning score as two BCD digits (11 points).
- PAUSE_FRAMES, 120, frame ticks the ball is held still between serves (2 s at 60 Hz).
- OVER_FRAMES, 180, frame ticks the game-over screen ignores buttons.

Ports:
- clk  in  1  system clock (pixel-rate domain, same as the graph block).
- reset_n  in  1  asynchronous, active-low reset.
- pix_x  in  10  current pixel column from the sync generator.
- pix_y  in  10  current pixel row from the sync generator.
- btn  in  4  player buttons, active-high, already debounced.
- left_miss  in  1  ball escaped past the left paddle (level, may stay high many cycles).
- right_miss  in  1  ball escaped past the right paddle (level).
- gra_still  out  1  hold the ball centred and load the serve direction.
- next_toss  out  2  serve direction: [1]=1 means -x, [0]=1 means -y.
- score_l  out  8  left player score, two BCD digits.
- score_r  out  8  right player score, two BCD digits.
- winner  out  2  2'b00 none, 2'b01 left, 2'b10 right.
- game_state  out  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER (for the text overlay).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=NEWGAME, gra_still=1, next_toss=2'b00, score_l=score_r=8'h00, winner=2'b00.
  - Timer=0, toggle bit=0, btn history=0.
  - Reset asserted mid-game aborts immediately to these values.
- Frame tick: one-cycle tick when pix_y==481 and pix_x==0, generated internally.
- Toggle bit: flips on every frame tick and supplies next_toss[0].
- Button edge: btn_edge = |(btn & ~btn_prev). btn_prev is registered every clk.
- Timer:
  - 8-bit down-counter. It decrements only on a frame tick while non-zero.
  - It is loaded on the transitions listed below.
  - timer_done = (timer==0).
- gra_still = 1 in every state except PLAY. It is a registered output that changes together with game_state.
- State NEWGAME:
  - scores stay at 0 and winner=00.
  - btn_edge → PLAY in the next cycle.
- State PLAY, evaluated every clk:
  - Both misses high in the same cycle: no score change. next_toss[1] keeps its previous value. Load PAUSE_FRAMES, go to NEWBALL.
  - left_miss only:
    - score_r increments in BCD (ones digit 9 wraps to 0 with a carry into tens; tens is capped at 9).
    - next_toss <= {1'b1, toggle}, so the serve goes toward the player who missed.
    - If the incremented score_r equals WIN_BCD: winner=10, load OVER_FRAMES, go to OVER.
    - Otherwise: load PAUSE_FRAMES, go to NEWBALL.
  - right_miss only: mirror image. score_l increments, next_toss <= {1'b0, toggle}, winner=01 when the win is reached.
  - Only one score update happens per serve, because the state leaves PLAY in the same cycle the miss is seen. Miss levels seen in any other state are ignored.
- State NEWBALL: timer_done → PLAY. Buttons are ignored.
- State OVER:
  - scores and winner are held.
  - btn_edge with timer_done → NEWGAME, clearing the scores and winner in that same transition.
  - btn_edge before timer_done is discarded and does not take effect later.
- next_toss is stable throughout NEWBALL/NEWGAME, so the animator samples a constant value while gra_still=1.

Decomposition:
- Shared package pong_pkg holds:
  - state encodings (ST_NEWGAME, ST_PLAY, ST_NEWBALL, ST_OVER);
  - winner codes;
  - MAX_X/MAX_Y and the frame-tick row (481), shared with the graph block.
- One natural sub-module: bcd_score_cnt, a two-digit BCD counter with clr, inc, saturation at 99, and asynchronous active-low reset. It is instantiated twice.

Test Plan:
- Reset, then a btn[0] pulse → game_state 00→01 one clk after the edge; gra_still falls to 0; scores are 00/00.
- In PLAY, hold left_miss high for 50 clks → score_r=8'h01 (exactly once), next_toss[1]=1, state=NEWBALL, gra_still=1; after 120 frame ticks → PLAY.
- Preload score_l=8'h09, then right_miss → score_l=8'h10 (BCD carry), state NEWBALL.
- score_r=8'h10, then left_miss → score_r=8'h11, winner=10, state OVER; a btn edge at tick 100 is ignored; a btn edge after tick 180 → NEWGAME with scores 00/00 and winner 00.
- left_miss and right_miss asserted in the same clk → scores unchanged, state NEWBALL.
- Drop reset_n during NEWBALL with score_l=8'h05 → all outputs at their reset values immediately, with no clk edge needed.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared encodings and helpers for the two-player pong screen
// Purpose: game-state and winner codes, screen geometry shared with the graph
//          block, and the saturating two-digit BCD increment used for scoring.
// Ports:   none (package).
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam logic [9:0] MAX_X          = 10'd640;
  localparam logic [9:0] MAX_Y          = 10'd480;
  // First row below the visible area; the graph block advances its objects here.
  localparam logic [9:0] FRAME_TICK_ROW = MAX_Y + 10'd1;

  // Two-digit BCD +1: ones wrap 9->0 with carry, whole value holds at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_score_cnt.sv
// rtl/bcd_score_cnt.sv - two-digit BCD score counter with clear and saturation
// Purpose: holds one player's score as two BCD digits.
// Ports:   clk, reset_n (async active-low), i_clr (clear to 00, wins over inc),
//          i_inc (add one point, saturates at 99), o_score (BCD score).
module bcd_score_cnt
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [7:0] o_score
);

  logic [7:0] r_score;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_score <= 8'h00;
    else if (i_clr)
      r_score <= 8'h00;
    else if (i_inc)
      r_score <= bcd_inc(r_score);
  end

  assign o_score = r_score;

endmodule

// File: rtl/pong_2p_ctrl.sv
// rtl/pong_2p_ctrl.sv - two-player pong game-control FSM (scores, serve pause, winner)
// Purpose: consumes the graph animator's miss levels, keeps both BCD scores,
//          times the pause between balls and the game-over lockout, and drives
//          gra_still/next_toss back to the animator.
// Ports:   clk, reset_n (async active-low); pix_x/pix_y (sync position, used for
//          the frame tick); btn (debounced, active-high); left_miss/right_miss
//          (levels); gra_still, next_toss ([1]=-x, [0]=-y); score_l/score_r (BCD);
//          winner (00 none, 01 left, 10 right); game_state (for the text overlay).
module pong_2p_ctrl
  import pong_pkg::*;
#(
  parameter logic [7:0] WIN_BCD      = 8'h11,
  parameter int         PAUSE_FRAMES = 120,
  parameter int         OVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [3:0] btn,
  input  logic       left_miss,
  input  logic       right_miss,
  output logic       gra_still,
  output logic [1:0] next_toss,
  output logic [7:0] score_l,
  output logic [7:0] score_r,
  output logic [1:0] winner,
  output logic [1:0] game_state
);

  state_t     r_state;
  logic       r_gra_still;
  logic [1:0] r_next_toss;
  logic [1:0] r_winner;
  logic [7:0] r_timer;
  logic       r_toggle;
  logic [3:0] r_btn_prev;

  logic       w_tick;
  logic       w_btn_edge;
  logic       w_timer_done;
  logic       w_play;
  logic       w_inc_l;
  logic       w_inc_r;
  logic       w_clr;
  logic       w_win_l;
  logic       w_win_r;
  logic [7:0] w_score_l;
  logic [7:0] w_score_r;

  assign w_tick       = (pix_y == FRAME_TICK_ROW) && (pix_x == 10'd0);
  assign w_btn_edge   = |(btn & ~r_btn_prev);
  assign w_timer_done = (r_timer == 8'd0);
  assign w_play       = (r_state == ST_PLAY);

  // A miss on one side scores for the other; simultaneous misses score nobody.
  assign w_inc_r = w_play && left_miss && !right_miss;
  assign w_inc_l = w_play && right_miss && !left_miss;
  assign w_clr   = (r_state == ST_OVER) && w_btn_edge && w_timer_done;

  // Win is judged on the value the score is about to take.
  assign w_win_l = (bcd_inc(w_score_l) == WIN_BCD);
  assign w_win_r = (bcd_inc(w_score_r) == WIN_BCD);

  bcd_score_cnt u_score_l (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_clr),
    .i_inc   (w_inc_l),
    .o_score (w_score_l)
  );

  bcd_score_cnt u_score_r (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_clr),
    .i_inc   (w_inc_r),
    .o_score (w_score_r)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_prev <= 4'd0;
      r_toggle   <= 1'b0;
    end else begin
      r_btn_prev <= btn;
      if (w_tick)
        r_toggle <= ~r_toggle;
    end
  end

  // Timer decrement is the default; a state transition that loads it overrides.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_NEWGAME;
      r_gra_still <= 1'b1;
      r_next_toss <= 2'b00;
      r_winner    <= WIN_NONE;
      r_timer     <= 8'd0;
    end else begin
      if (w_tick && !w_timer_done)
        r_timer <= r_timer - 8'd1;
      case (r_state)
        ST_NEWGAME: begin
          if (w_btn_edge) begin
            r_state     <= ST_PLAY;
            r_gra_still <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (left_miss || right_miss) begin
            r_gra_still <= 1'b1;
            r_state     <= ST_NEWBALL;
            r_timer     <= 8'(PAUSE_FRAMES);
            if (left_miss && !right_miss) begin
              r_next_toss <= {1'b1, r_toggle};
              if (w_win_r) begin
                r_winner <= WIN_RIGHT;
                r_state  <= ST_OVER;
                r_timer  <= 8'(OVER_FRAMES);
              end
            end else if (right_miss && !left_miss) begin
              r_next_toss <= {1'b0, r_toggle};
              if (w_win_l) begin
                r_winner <= WIN_LEFT;
                r_state  <= ST_OVER;
                r_timer  <= 8'(OVER_FRAMES);
              end
            end
          end
        end
        ST_NEWBALL: begin
          if (w_timer_done) begin
            r_state     <= ST_PLAY;
            r_gra_still <= 1'b0;
          end
        end
        ST_OVER: begin
          if (w_clr) begin
            r_state  <= ST_NEWGAME;
            r_winner <= WIN_NONE;
          end
        end
        default: r_state <= ST_NEWGAME;
      endcase
    end
  end

  assign gra_still  = r_gra_still;
  assign next_toss  = r_next_toss;
  assign score_l    = w_score_l;
  assign score_r    = w_score_r;
  assign winner     = r_winner;
  assign game_state = r_state;

endmodule

// File: tb/tb_pong_2p_ctrl.sv
// tb/tb_pong_2p_ctrl.sv - directed self-checking bench for pong_2p_ctrl
module tb_pong_2p_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] pix_x = 10'd0;
  logic [9:0] pix_y = 10'd0;
  logic [3:0] btn = 4'd0;
  logic       left_miss = 1'b0;
  logic       right_miss = 1'b0;
  logic       gra_still;
  logic [1:0] next_toss;
  logic [7:0] score_l;
  logic [7:0] score_r;
  logic [1:0] winner;
  logic [1:0] game_state;

  int checks = 0;
  int errors = 0;

  pong_2p_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .btn        (btn),
    .left_miss  (left_miss),
    .right_miss (right_miss),
    .gra_still  (gra_still),
    .next_toss  (next_toss),
    .score_l    (score_l),
    .score_r    (score_r),
    .winner     (winner),
    .game_state (game_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk) pix_y = 10'd481;
    @(negedge clk) pix_y = 10'd0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // 120 ticks empty the pause timer; the state moves to PLAY one clk later.
  task automatic wait_serve();
    ticks(120);
    chk("pause_last_tick_state", 8'(game_state), 8'h02);
    @(negedge clk);
    chk("serve_state", 8'(game_state), 8'h01);
    chk("serve_still", 8'(gra_still), 8'h00);
  endtask

  task automatic pulse_left();
    @(negedge clk) left_miss = 1'b1;
    @(negedge clk) left_miss = 1'b0;
  endtask

  task automatic pulse_right();
    @(negedge clk) right_miss = 1'b1;
    @(negedge clk) right_miss = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk) btn = b;
    @(negedge clk) btn = 4'd0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", 8'(game_state), 8'h00);
    chk("rst_still", 8'(gra_still), 8'h01);
    chk("rst_toss", 8'(next_toss), 8'h00);
    chk("rst_score_l", score_l, 8'h00);
    chk("rst_score_r", score_r, 8'h00);
    chk("rst_winner", 8'(winner), 8'h00);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_newgame", 8'(game_state), 8'h00);

    press(4'b0001);
    chk("start_state", 8'(game_state), 8'h01);
    chk("start_still", 8'(gra_still), 8'h00);
    chk("start_scores", {score_l[3:0], score_r[3:0]}, 8'h00);

    // Long miss level must score only once.
    @(negedge clk) left_miss = 1'b1;
    repeat (50) @(negedge clk);
    left_miss = 1'b0;
    chk("lmiss_score_r", score_r, 8'h01);
    chk("lmiss_score_l", score_l, 8'h00);
    chk("lmiss_toss", 8'(next_toss), 8'h02);
    chk("lmiss_state", 8'(game_state), 8'h02);
    chk("lmiss_still", 8'(gra_still), 8'h01);
    wait_serve();

    for (int i = 1; i <= 10; i++) begin
      if (i == 10) tick();
      pulse_right();
      if (i == 9) chk("rmiss_score_l_09", score_l, 8'h09);
      if (i == 10) begin
        chk("rmiss_bcd_carry", score_l, 8'h10);
        chk("rmiss_state", 8'(game_state), 8'h02);
        chk("rmiss_toss_toggle", 8'(next_toss), 8'h01);
      end
      wait_serve();
    end

    @(negedge clk) begin left_miss = 1'b1; right_miss = 1'b1; end
    @(negedge clk) begin left_miss = 1'b0; right_miss = 1'b0; end
    chk("both_score_l", score_l, 8'h10);
    chk("both_score_r", score_r, 8'h01);
    chk("both_state", 8'(game_state), 8'h02);
    chk("both_toss", 8'(next_toss), 8'h01);
    wait_serve();

    for (int i = 2; i <= 10; i++) begin
      pulse_left();
      if (i == 10) begin
        chk("lmiss_score_r_10", score_r, 8'h10);
        chk("lmiss_no_winner", 8'(winner), 8'h00);
        chk("lmiss_toss_11", 8'(next_toss), 8'h03);
      end
      wait_serve();
    end

    pulse_left();
    chk("win_score_r", score_r, 8'h11);
    chk("win_winner", 8'(winner), 8'h02);
    chk("win_state", 8'(game_state), 8'h03);
    chk("win_still", 8'(gra_still), 8'h01);
    chk("win_score_l", score_l, 8'h10);

    ticks(100);
    press(4'b0100);
    chk("over_early_btn", 8'(game_state), 8'h03);
    ticks(80);
    @(negedge clk);
    chk("over_stale_edge", 8'(game_state), 8'h03);
    chk("over_hold_winner", 8'(winner), 8'h02);
    chk("over_hold_score", score_r, 8'h11);
    press(4'b0010);
    chk("restart_state", 8'(game_state), 8'h00);
    chk("restart_score_l", score_l, 8'h00);
    chk("restart_score_r", score_r, 8'h00);
    chk("restart_winner", 8'(winner), 8'h00);
    chk("restart_still", 8'(gra_still), 8'h01);

    press(4'b1000);
    chk("game2_state", 8'(game_state), 8'h01);
    for (int i = 1; i <= 5; i++) begin
      pulse_right();
      if (i < 5) wait_serve();
    end
    chk("pre_rst_score_l", score_l, 8'h05);
    chk("pre_rst_state", 8'(game_state), 8'h02);

    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_state", 8'(game_state), 8'h00);
    chk("async_rst_still", 8'(gra_still), 8'h01);
    chk("async_rst_toss", 8'(next_toss), 8'h00);
    chk("async_rst_score_l", score_l, 8'h00);
    chk("async_rst_score_r", score_r, 8'h00);
    chk("async_rst_winner", 8'(winner), 8'h00);
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
